// File: rtl/fo_generator.sv
// -----------------------------------------------------------------------------
// fo_generator
//
// Feeds the largest/duplicate element detector of the comparison-free sorting
// engine.
//
// Operation:
//   1. Loads ELEMENT_NUM unsigned elements, one per accepted beat.
//   2. Walks the value space downwards, from all-ones to zero.
//   3. For every value still held by one or more unsorted elements, it emits
//      one FO mask. Bit i of the mask is set when element i holds that value.
//   4. It does not issue the next mask until the detector has drained the
//      current one. As a result, elements leave in descending order.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   load_valid  load_data carries a valid element
//   load_data   element written at the current load index
//   load_ready  high while loading; a beat is taken on load_valid && load_ready
//   ldd_busy    detector still holds FO bits (detector out_valid)
//   fo_valid    one-cycle pulse qualifying FO / fo_value (detector in_valid)
//   FO          match mask for fo_value
//   fo_value    value shared by every element flagged in FO
//   done        one-cycle pulse once the last mask has drained
// -----------------------------------------------------------------------------
module fo_generator #(
    parameter int ELEMENT_NUM      = 16,
    parameter int LOG2_ELEMENT_NUM = 4,
    parameter int DATA_WIDTH       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_valid,
    input  logic [DATA_WIDTH-1:0]       load_data,
    output logic                        load_ready,
    input  logic                        ldd_busy,
    output logic                        fo_valid,
    output logic [ELEMENT_NUM-1:0]      FO,
    output logic [DATA_WIDTH-1:0]       fo_value,
    output logic                        done
);

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [LOG2_ELEMENT_NUM-1:0] LAST_IDX  = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);
    localparam logic [LOG2_ELEMENT_NUM-1:0] IDX_ONE   = {{(LOG2_ELEMENT_NUM-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]       VAL_ONES  = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0]       VAL_ZERO  = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]       VAL_ONE   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ELEMENT_NUM-1:0]      MASK_ZERO = {ELEMENT_NUM{1'b0}};

    state_t                      state_q;
    logic [LOG2_ELEMENT_NUM-1:0] load_idx_q;
    logic [ELEMENT_NUM-1:0]      remaining_q;
    logic [DATA_WIDTH-1:0]       scan_cnt_q;
    logic [DATA_WIDTH-1:0]       scan_cnt_dec_d;
    logic                        wait_first_q;
    logic [DATA_WIDTH-1:0]       elem_q [ELEMENT_NUM];
    logic                        load_ready_q;
    logic                        fo_valid_q;
    logic [ELEMENT_NUM-1:0]      fo_q;
    logic [DATA_WIDTH-1:0]       fo_value_q;
    logic                        done_q;
    logic [ELEMENT_NUM-1:0]      match_s;

    assign load_ready     = load_ready_q;
    assign fo_valid       = fo_valid_q;
    assign FO             = fo_q;
    assign fo_value       = fo_value_q;
    assign done           = done_q;
    assign scan_cnt_dec_d = scan_cnt_q - VAL_ONE;

    // Elements still waiting to be issued that hold the value under scan
    always_comb begin
        match_s = MASK_ZERO;
        for (int i = 0; i < ELEMENT_NUM; i++) begin
            match_s[i] = remaining_q[i] && (elem_q[i] == scan_cnt_q);
        end
    end

    // Sort FSM: element storage, scan counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            load_idx_q   <= {LOG2_ELEMENT_NUM{1'b0}};
            remaining_q  <= MASK_ZERO;
            scan_cnt_q   <= VAL_ONES;
            wait_first_q <= 1'b0;
            load_ready_q <= 1'b1;
            fo_valid_q   <= 1'b0;
            fo_q         <= MASK_ZERO;
            fo_value_q   <= VAL_ZERO;
            done_q       <= 1'b0;
            for (int i = 0; i < ELEMENT_NUM; i++) begin
                elem_q[i] <= VAL_ZERO;
            end
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load_valid) begin
                        elem_q[load_idx_q]      <= load_data;
                        remaining_q[load_idx_q] <= 1'b1;
                        if (load_idx_q == LAST_IDX) begin
                            load_idx_q   <= {LOG2_ELEMENT_NUM{1'b0}};
                            scan_cnt_q   <= VAL_ONES;
                            load_ready_q <= 1'b0;
                            state_q      <= ST_SCAN;
                        end else begin
                            load_idx_q <= load_idx_q + IDX_ONE;
                        end
                    end
                end
                ST_SCAN: begin
                    // While anything remains, some value at or below scan_cnt
                    // must match, so the counter never wraps here.
                    if (match_s != MASK_ZERO) begin
                        fo_q       <= match_s;
                        fo_value_q <= scan_cnt_q;
                        fo_valid_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end else begin
                        scan_cnt_q <= scan_cnt_dec_d;
                    end
                end
                ST_ISSUE: begin
                    fo_valid_q   <= 1'b0;
                    remaining_q  <= remaining_q & ~fo_q;
                    wait_first_q <= 1'b1;
                    state_q      <= ST_WAIT;
                    if (scan_cnt_q != VAL_ZERO) begin
                        scan_cnt_q <= scan_cnt_dec_d;
                    end
                end
                ST_WAIT: begin
                    // The detector raises busy one cycle after fo_valid, so the
                    // first WAIT cycle cannot trust ldd_busy.
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else if (!ldd_busy) begin
                        if (remaining_q == MASK_ZERO) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    done_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                    state_q      <= ST_LOAD;
                end
                default: begin
                    fo_valid_q   <= 1'b0;
                    done_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                    load_idx_q   <= {LOG2_ELEMENT_NUM{1'b0}};
                    state_q      <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fo_generator.sv
// -----------------------------------------------------------------------------
// tb_fo_generator
//
// Directed, table-driven bench for fo_generator. Each table entry is one sort
// batch with hand-computed expectations:
//   - mask count
//   - first FO and first fo_value
//   - latency from the last load beat to the first fo_valid
//
// The ldd_busy input is modelled by a small detector. It stays busy for one
// cycle per FO bit, starting the cycle after fo_valid.
//
// Hand-written sequences cover:
//   - the long busy hold
//   - a mid-batch reset
// -----------------------------------------------------------------------------
module tb_fo_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_ready;
    logic        ldd_busy;
    logic        fo_valid;
    logic [15:0] FO;
    logic [7:0]  fo_value;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          det_cnt;
    logic        extra_busy;

    logic [7:0]  ev_val [$];
    logic [15:0] ev_fo [$];
    int          ev_cyc [$];
    int          done_cyc [$];
    bit          overlap;
    int          last_beat_cyc;
    int          fall_cyc;
    logic [7:0]  cur_e [16];

    typedef struct {
        logic [7:0]  e [16];
        int          n_masks;
        logic [15:0] first_fo;
        logic [7:0]  first_val;
        int          first_lat;
        bit          stray;
        bit          hold;
    } vec_t;

    vec_t vecs [5];

    fo_generator #(
        .ELEMENT_NUM      (16),
        .LOG2_ELEMENT_NUM (4),
        .DATA_WIDTH       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ldd_busy   (ldd_busy),
        .fo_valid   (fo_valid),
        .FO         (FO),
        .fo_value   (fo_value),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign ldd_busy = (det_cnt != 0) || extra_busy;

    // Detector model: busy for popcount(FO) cycles, starting the cycle after fo_valid
    always @(posedge clk or posedge rst) begin
        if (rst) det_cnt <= 0;
        else if (fo_valid) det_cnt <= $countones(FO);
        else if (det_cnt != 0) det_cnt <= det_cnt - 1;
    end

    // Event logger, sampled on the inactive edge
    always @(negedge clk) begin
        if (fo_valid) begin
            ev_val.push_back(fo_value);
            ev_fo.push_back(FO);
            ev_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (fo_valid && done) overlap = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic load_batch(input bit stray);
        int not_ready = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_data  = cur_e[i];
            if (load_ready !== 1'b1) not_ready++;
        end
        last_beat_cyc = cyc;
        @(negedge clk);
        load_valid = stray;
        load_data  = 8'hFF;
        chk("load_ready_during_beats", not_ready, 0);
    endtask

    task automatic wait_done();
        bit ok  = 1'b0;
        int rdy = 0;
        for (int k = 0; k < 3000; k++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (load_ready !== 1'b0) rdy++;
            @(negedge clk);
        end
        load_valid = 1'b0;
        #1;
        chk("done_within_budget", int'(ok), 1);
        chk("load_ready_outside_load", rdy, 0);
    endtask

    task automatic hold_busy();
        bit seen = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (fo_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("hold_first_fo_seen", int'(seen), 1);
        extra_busy = 1'b1;
        repeat (10) @(negedge clk);
        chk("hold_no_fo_while_busy", ev_val.size(), 1);
        extra_busy = 1'b0;
        fall_cyc   = cyc;
    endtask

    task automatic run_vec(input int vi);
        logic [7:0]  rv [$];
        logic [15:0] rf [$];
        logic [15:0] m;
        int          n;
        int          last;
        cur_e = vecs[vi].e;
        ev_val.delete();
        ev_fo.delete();
        ev_cyc.delete();
        done_cyc.delete();
        overlap = 1'b0;
        load_batch(vecs[vi].stray);
        if (vecs[vi].hold) hold_busy();
        wait_done();

        // Independent reference: descending values, one mask per present value
        for (int v = 255; v >= 0; v--) begin
            m = 16'h0000;
            for (int i = 0; i < 16; i++) if (cur_e[i] == 8'(v)) m[i] = 1'b1;
            if (m != 16'h0000) begin
                rv.push_back(8'(v));
                rf.push_back(m);
            end
        end

        chk("mask_count", ev_val.size(), vecs[vi].n_masks);
        chk("ref_mask_count", rv.size(), vecs[vi].n_masks);
        n = (ev_val.size() < rv.size()) ? ev_val.size() : rv.size();
        if (n > 0) begin
            chk("first_fo", int'(ev_fo[0]), int'(vecs[vi].first_fo));
            chk("first_value", int'(ev_val[0]), int'(vecs[vi].first_val));
            chk("first_latency", ev_cyc[0] - last_beat_cyc, vecs[vi].first_lat);
        end
        for (int k = 0; k < n; k++) begin
            chk("mask_value", int'(ev_val[k]), int'(rv[k]));
            chk("mask_fo", int'(ev_fo[k]), int'(rf[k]));
            if (k > 0 && !vecs[vi].hold)
                chk("mask_gap", ev_cyc[k] - ev_cyc[k-1],
                    $countones(rf[k-1]) + 2 + int'(rv[k-1]) - int'(rv[k]));
        end
        if (vecs[vi].hold && n > 1) chk("hold_resume_gap", ev_cyc[1] - fall_cyc, 2);
        chk("done_pulses", done_cyc.size(), 1);
        if (done_cyc.size() > 0 && ev_cyc.size() > 0 && rf.size() > 0) begin
            last = ev_cyc.size() - 1;
            chk("done_lag", done_cyc[0] - ev_cyc[last], $countones(rf[rf.size()-1]) + 2);
        end
        chk("fo_done_overlap", int'(overlap), 0);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        extra_busy = 1'b0;

        vecs[0].e = '{8'd7, 8'd2, 8'd12, 8'd0, 8'd15, 8'd9, 8'd4, 8'd11,
                      8'd1, 8'd14, 8'd6, 8'd3, 8'd10, 8'd13, 8'd5, 8'd8};
        vecs[0].n_masks = 16; vecs[0].first_fo = 16'h0010; vecs[0].first_val = 8'd15;
        vecs[0].first_lat = 242; vecs[0].stray = 1'b0; vecs[0].hold = 1'b0;

        for (int i = 0; i < 16; i++) vecs[1].e[i] = 8'hAA;
        vecs[1].n_masks = 1; vecs[1].first_fo = 16'hFFFF; vecs[1].first_val = 8'hAA;
        vecs[1].first_lat = 87; vecs[1].stray = 1'b0; vecs[1].hold = 1'b0;

        vecs[2].e = '{8'd0, 8'd10, 8'd20, 8'd200, 8'd40, 8'd50, 8'd60, 8'd70,
                      8'd80, 8'd200, 8'd100, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150};
        vecs[2].n_masks = 15; vecs[2].first_fo = 16'h0208; vecs[2].first_val = 8'd200;
        vecs[2].first_lat = 57; vecs[2].stray = 1'b0; vecs[2].hold = 1'b0;

        vecs[3].e = '{8'd128, 8'd0, 8'd255, 8'd128, 8'd64, 8'd64, 8'd64, 8'd0,
                      8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        vecs[3].n_masks = 12; vecs[3].first_fo = 16'h0004; vecs[3].first_val = 8'd255;
        vecs[3].first_lat = 2; vecs[3].stray = 1'b1; vecs[3].hold = 1'b0;

        vecs[4].e[0] = 8'd100;
        for (int i = 1; i < 16; i++) vecs[4].e[i] = 8'd99;
        vecs[4].n_masks = 2; vecs[4].first_fo = 16'h0001; vecs[4].first_val = 8'd100;
        vecs[4].first_lat = 157; vecs[4].stray = 1'b0; vecs[4].hold = 1'b1;

        #1;
        chk("reset_load_ready", int'(load_ready), 1);
        chk("reset_fo_valid", int'(fo_valid), 0);
        chk("reset_FO", int'(FO), 0);
        chk("reset_fo_value", int'(fo_value), 0);
        chk("reset_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) run_vec(v);

        // Mid-batch reset during SCAN discards the batch immediately
        cur_e = vecs[1].e;
        ev_val.delete();
        ev_fo.delete();
        ev_cyc.delete();
        done_cyc.delete();
        load_batch(1'b0);
        repeat (20) @(negedge clk);
        chk("pre_reset_no_fo", ev_val.size(), 0);
        rst = 1'b1;
        #1;
        chk("midrst_fo_valid", int'(fo_valid), 0);
        chk("midrst_FO", int'(FO), 0);
        chk("midrst_fo_value", int'(fo_value), 0);
        chk("midrst_load_ready", int'(load_ready), 1);
        chk("midrst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
